// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode transmitter.
// Optional feature macro used by the top level: BARCODE_TX_GAP_EN.
package barcode_pkg;

  localparam int PERIOD_W_DEF = 22;
  localparam int BITS_PER_ID  = 8;
  localparam int GAP_QUARTERS = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    GAP
  } bc_tx_state_t;

  // Number of quarters the line stays low at the start of a symbol.
  function automatic logic [1:0] low_quarters(input logic is_start, input logic data_bit);
    logic [1:0] n;
    if (is_start)      n = 2'd2;
    else if (data_bit) n = 2'd1;
    else               n = 2'd3;
    return n;
  endfunction

endpackage

// File: rtl/barcode_tick_gen.sv
// Quarter-period tick generator: emits a one-cycle qtick every Q clocks.
// Held at zero while clr is high so the first tick lands exactly Q clocks
// after clr drops.
module barcode_tick_gen #(
  parameter int QW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [QW-1:0] Q,
  output logic          qtick
);

  logic [QW-1:0] cnt_q, cnt_d;

  assign qtick = !clr && (cnt_q == (Q - QW'(1)));

  // Next count: clear, wrap on tick, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + QW'(1);
    if (clr || qtick) cnt_d = '0;
  end

  // Tick counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/barcode_tx.sv
// Barcode waveform transmitter: start bit plus 8 data bits, MSB first,
// each bit 4Q clocks starting with a falling edge.
// Define BARCODE_TX_GAP_EN to append a 16Q high guard interval before done.
module barcode_tx
  import barcode_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                send,
  input  logic [7:0]          ID,
  input  logic [PERIOD_W-1:0] period,
  output logic                BC,
  output logic                busy,
  output logic                done
);

  localparam int QW = PERIOD_W - 2;

  bc_tx_state_t  state_q;
  logic [3:0]    qcnt_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    shreg_q;
  logic [QW-1:0] q_q;
  logic          bc_q, busy_q, done_q;

  logic          qtick, tick_clr, accept, shift, rise;
  logic [1:0]    low_n;
  logic          unused_period_lsbs;

  // Quarter length is the period divided by four; the two LSBs carry no weight.
  assign unused_period_lsbs = ^period[1:0];

  function automatic logic [QW-1:0] clamp_q(input logic [QW-1:0] raw);
    return (raw == '0) ? QW'(1) : raw;
  endfunction

  assign tick_clr = (state_q == IDLE);
  assign accept   = tick_clr && send;
  assign shift    = (state_q == DATA) && qtick && (qcnt_q == 4'd3);
  assign low_n    = low_quarters(state_q == START, shreg_q[7]);
  assign rise     = qtick && ((qcnt_q + 4'd1) == {2'b00, low_n});

  barcode_tick_gen #(.QW(QW)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .Q     (q_q),
    .qtick (qtick)
  );

  // Frame payload and quarter length, captured on an accepted send.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg_q <= ID;
      q_q     <= clamp_q(period[PERIOD_W-1:2]);
    end else if (shift) begin
      shreg_q <= {shreg_q[6:0], 1'b0};
    end
  end

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
      bcnt_q  <= '0;
      bc_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          bc_q   <= 1'b1;
          busy_q <= 1'b0;
          qcnt_q <= '0;
          bcnt_q <= '0;
          if (accept) begin
            state_q <= START;
            bc_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (qtick) begin
            if (qcnt_q == 4'd3) begin
              qcnt_q  <= '0;
              bcnt_q  <= '0;
              state_q <= DATA;
              bc_q    <= 1'b0;
            end else begin
              qcnt_q <= qcnt_q + 4'd1;
              if (rise) bc_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (qtick) begin
            if (qcnt_q == 4'd3) begin
              qcnt_q <= '0;
              if (bcnt_q == 3'(BITS_PER_ID - 1)) begin
`ifdef BARCODE_TX_GAP_EN
                // Line is already high; hold it through the guard interval.
                state_q <= GAP;
`else
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`endif
              end else begin
                bcnt_q <= bcnt_q + 3'd1;
                bc_q   <= 1'b0;
              end
            end else begin
              qcnt_q <= qcnt_q + 4'd1;
              if (rise) bc_q <= 1'b1;
            end
          end
        end
`ifdef BARCODE_TX_GAP_EN
        GAP: begin
          bc_q <= 1'b1;
          if (qtick) begin
            if (qcnt_q == 4'(GAP_QUARTERS - 1)) begin
              qcnt_q  <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              qcnt_q <= qcnt_q + 4'd1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          qcnt_q  <= '0;
          bcnt_q  <= '0;
          bc_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BC   = bc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_barcode_tx.sv
// Self-checking bench for barcode_tx. Expected line levels come from a
// symbol-level model (low/high run lengths per bit) built into a queue.
module tb_barcode_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [7:0]  ID = '0;
  logic [21:0] period = '0;
  logic        BC, busy, done;

  int tests = 0;
  int fails = 0;
  logic exp_bc[$];

  always #5 clk = ~clk;

  barcode_tx #(.PERIOD_W(22)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .send   (send),
    .ID     (ID),
    .period (period),
    .BC     (BC),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int qlen(input logic [21:0] per);
    int q;
    q = int'(per[21:2]);
    return (q == 0) ? 1 : q;
  endfunction

  // Expected BC level for every cycle of a frame, starting at the falling edge.
  function automatic void build_model(input logic [7:0] id, input logic [21:0] per);
    int q;
    int lo;
    q = qlen(per);
    exp_bc.delete();
    repeat (2 * q) exp_bc.push_back(1'b0);
    repeat (2 * q) exp_bc.push_back(1'b1);
    for (int b = 7; b >= 0; b--) begin
      lo = id[b] ? q : 3 * q;
      repeat (lo) exp_bc.push_back(1'b0);
      repeat (4 * q - lo) exp_bc.push_back(1'b1);
    end
`ifdef BARCODE_TX_GAP_EN
    repeat (16 * q) exp_bc.push_back(1'b1);
`endif
  endfunction

  task automatic kick(input logic [7:0] id, input logic [21:0] per);
    send   = 1'b1;
    ID     = id;
    period = per;
  endtask

  // Follows one frame whose send is already on the inputs. again_k >= 0 pulses
  // send mid-frame; chain sends the next frame in the done cycle.
  task automatic check_frame(input logic [7:0] id, input logic [21:0] per, input int again_k,
                             input bit chain, input logic [7:0] nid, input logic [21:0] nper);
    build_model(id, per);
    @(posedge clk);
    #1;
    send   = 1'b0;
    ID     = 8'($urandom);
    period = 22'($urandom_range(0, 40));
    for (int k = 0; k < exp_bc.size(); k++) begin
      @(negedge clk);
      chk($sformatf("bc[%0d] id=%0h", k, id), {31'b0, BC}, {31'b0, exp_bc[k]});
      chk($sformatf("busy[%0d]", k), {31'b0, busy}, 32'd1);
      chk($sformatf("done_early[%0d]", k), {31'b0, done}, 32'd0);
      if (k == again_k) send = 1'b1;
      else if (k == again_k + 1) send = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("done id=%0h", id), {31'b0, done}, 32'd1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    chk("bc_at_done", {31'b0, BC}, 32'd1);
    if (chain) begin
      kick(nid, nper);
    end else begin
      @(negedge clk);
      chk("done_width", {31'b0, done}, 32'd0);
      chk("idle_line", {30'b0, busy, BC}, 32'd1);
    end
  endtask

  initial begin
    logic [7:0]  a_id, b_id;
    logic [21:0] a_per, b_per;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bc", {31'b0, BC}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;

    // 0xA5 at Q=4 with an ignored send 20 cycles in
    @(posedge clk); #1;
    kick(8'hA5, 22'd16);
    check_frame(8'hA5, 22'd16, 20, 1'b0, 8'h00, 22'd0);

    // Q clamps to 1, all-zero data
    @(posedge clk); #1;
    kick(8'h00, 22'd2);
    check_frame(8'h00, 22'd2, -1, 1'b0, 8'h00, 22'd0);

    // Random back-to-back pairs
    for (int i = 0; i < 3; i++) begin
      a_id  = 8'($urandom);
      b_id  = 8'($urandom);
      a_per = 22'($urandom_range(0, 31));
      b_per = 22'($urandom_range(0, 31));
      @(posedge clk); #1;
      kick(a_id, a_per);
      check_frame(a_id, a_per, int'($urandom_range(0, 10)), 1'b1, b_id, b_per);
      check_frame(b_id, b_per, -1, 1'b0, 8'h00, 22'd0);
    end

    // Reset during data bit 3 (Q=3): line idles at once, no done follows
    @(posedge clk); #1;
    kick(8'h3C, 22'd12);
    @(posedge clk); #1;
    send = 1'b0;
    repeat (16 * 3 + 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_bc", {31'b0, BC}, 32'd1);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60 * 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst[%0d]", k), {29'b0, done, busy, BC}, 32'd1);
    end

    // Clean frame after reset
    a_id  = 8'($urandom);
    a_per = 22'($urandom_range(0, 31));
    @(posedge clk); #1;
    kick(a_id, a_per);
    check_frame(a_id, a_per, -1, 1'b0, 8'h00, 22'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
